// File: rtl/eq_seq_pkg.sv
// Shared types and constants for the equalizer band sequencer.
package eq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int N_TAPS_LO = 531;
    localparam int N_TAPS_HI = 1021;
    localparam int LAT_DEF   = 2;

endpackage

// File: rtl/eq_band_sequencer_seq_cnt.sv
// Loadable up-counter with a terminal-count flag against a runtime terminal value.
module seq_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/eq_band_sequencer.sv
// Per-sample FIR band sequencer: N_TAPS-cycle RUN window, LAT-cycle drain, one-cycle done pulse.
// Optional sticky overrun flag is built when SEQ_OVERRUN_EN is defined.
module eq_band_sequencer
    import eq_seq_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_HI,
    parameter int LAT    = LAT_DEF,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smpl_valid,
    input  logic             q_full,
    output logic             sequencing,
    output logic [CNT_W-1:0] tap_idx,
    output logic             busy,
    output logic             smpl_done,
    output logic             overrun,
    input  logic             clr_ovr,
    output seq_state_t       state_dbg
);

    localparam logic [CNT_W-1:0] TAP_LAST   = CNT_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LAT - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] count;
    logic             cnt_tc;
    logic             start;

    assign start = smpl_valid && q_full;

    // One counter serves both phases: it is reloaded to 0 on every phase change.
    seq_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .term     (cnt_term),
        .count    (count),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_term   = TAP_LAST;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_load   = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_next = DRAIN;
                    cnt_load   = 1'b1;
                end
            end
            DRAIN: begin
                cnt_en   = 1'b1;
                cnt_term = DRAIN_LAST;
                if (cnt_tc) begin
                    state_next = DONE;
                    cnt_load   = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_load   = 1'b1;
            end
        endcase
    end

    // Outputs are pure decodes of the state and counter flops.
    assign sequencing = (state == RUN);
    assign tap_idx    = sequencing ? count : '0;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign smpl_done  = (state == DONE);
    assign state_dbg  = state;

`ifdef SEQ_OVERRUN_EN
    logic ovr_q;

    // Set wins over clear so a coincident late sample is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (smpl_valid && busy) begin
            ovr_q <= 1'b1;
        end else if (clr_ovr) begin
            ovr_q <= 1'b0;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_clr_ovr;

    assign unused_clr_ovr = clr_ovr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Directed bench for eq_band_sequencer (N_TAPS=8, LAT=2) with a done-cycle scoreboard.
module tb_eq_band_sequencer;
    import eq_seq_pkg::*;

    localparam int N   = 8;
    localparam int LAT = 2;
    localparam int W   = 4;
`ifdef SEQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         smpl_valid = 1'b0;
    logic         q_full     = 1'b0;
    logic         clr_ovr    = 1'b0;
    logic         sequencing;
    logic [W-1:0] tap_idx;
    logic         busy;
    logic         smpl_done;
    logic         overrun;
    seq_state_t   state_dbg;

    eq_band_sequencer #(.N_TAPS(N), .LAT(LAT), .CNT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .smpl_valid (smpl_valid),
        .q_full     (q_full),
        .sequencing (sequencing),
        .tap_idx    (tap_idx),
        .busy       (busy),
        .smpl_done  (smpl_done),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr),
        .state_dbg  (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks    = 0;
    int          errors    = 0;
    logic [31:0] exp_q[$];
    int          exp_start = -1000;
    logic        exp_ovr   = 1'b0;
    int          run_len   = 0;
    int          last_high = -1000;
    int          b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Timeline model of the current run plus the done scoreboard and run properties.
    task automatic check_cycle();
        int          off;
        logic        e_seq;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_tap;
        logic [31:0] e_done_cyc;
        seq_state_t  e_st;
        off    = cyc - exp_start;
        e_seq  = (off >= 0) && (off < N);
        e_busy = (off >= 0) && (off < N + LAT);
        e_done = (off == N + LAT);
        e_tap  = e_seq ? 32'(off) : 32'd0;
        e_st   = e_seq ? RUN : (e_busy ? DRAIN : (e_done ? DONE : IDLE));
        chk("sequencing", 32'(sequencing), 32'(e_seq));
        chk("tap_idx", 32'(tap_idx), e_tap);
        chk("busy", 32'(busy), 32'(e_busy));
        chk("smpl_done", 32'(smpl_done), 32'(e_done));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("state", 32'(state_dbg), 32'(e_st));
        if (!rst_n) begin
            run_len   = 0;
            last_high = -1000;
        end else begin
            if (sequencing === 1'b1) begin
                run_len++;
                last_high = cyc;
                chk("run_len_le_n", 32'(run_len <= N), 32'd1);
            end else begin
                run_len = 0;
            end
            if (smpl_done === 1'b1) begin
                chk("done_gap", 32'(cyc), 32'(last_high + LAT + 1));
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(smpl_done), 32'd0);
                end else begin
                    e_done_cyc = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), e_done_cyc);
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    // One-cycle smpl_valid pulse in the current cycle.
    task automatic drive_sample(input logic qf, input logic accept, input logic in_run);
        smpl_valid = 1'b1;
        q_full     = qf;
        if (accept) begin
            exp_start = cyc + 1;
            exp_q.push_back(32'(cyc + N + LAT + 1));
        end
        if (in_run && OVR_EN) exp_ovr = 1'b1;
        next_cycle();
        smpl_valid = 1'b0;
    endtask

    initial begin
        // reset
        repeat (3) next_cycle();
        rst_n = 1'b1;
        b = cyc;

        // first run at cycle 10, back-to-back run accepted in DONE at cycle 21
        goto(b + 10);
        drive_sample(1'b1, 1'b1, 1'b0);
        goto(b + 21);
        drive_sample(1'b1, 1'b1, 1'b0);
        goto(b + 36);

        // sample with queue not full is ignored
        drive_sample(1'b0, 1'b0, 1'b0);
        goto(b + 42);

        // late samples in RUN and DRAIN, q_full drop mid-run, overrun set/clear
        b = cyc;
        goto(b + 10);
        drive_sample(1'b1, 1'b1, 1'b0);
        goto(b + 12);
        q_full = 1'b0;
        goto(b + 14);
        drive_sample(1'b1, 1'b0, 1'b1);
        goto(b + 16);
        clr_ovr = 1'b1;
        drive_sample(1'b1, 1'b0, 1'b1);
        clr_ovr = 1'b0;
        goto(b + 19);
        drive_sample(1'b1, 1'b0, 1'b1);
        goto(b + 24);
        clr_ovr = 1'b1;
        exp_ovr = 1'b0;
        next_cycle();
        clr_ovr = 1'b0;
        goto(b + 27);

        // asynchronous reset mid-run, then a clean run
        b = cyc;
        goto(b + 10);
        drive_sample(1'b1, 1'b1, 1'b0);
        goto(b + 15);
        rst_n     = 1'b0;
        exp_start = -1000;
        exp_q.delete();
        exp_ovr   = 1'b0;
        #1;
        chk("rst_sequencing", 32'(sequencing), 32'd0);
        chk("rst_tap_idx", 32'(tap_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_smpl_done", 32'(smpl_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        goto(b + 17);
        rst_n = 1'b1;
        goto(b + 20);
        drive_sample(1'b1, 1'b1, 1'b0);
        goto(b + 34);
        chk("done_missing", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
